// File: rtl/vip_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// vip_stream_arbiter_pkg : FSM state type, pixel width and 2-way RR pick
// Rev 1.0
// ============================================================================
package vip_stream_arbiter_pkg;

  localparam int VIP_DWIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Prefer the pointer channel when it requests, otherwise take the other one.
  function automatic logic vip_rr_pick(input logic [1:0] req, input logic ptr);
    return req[ptr] ? ptr : ~ptr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vip_stream_arbiter.sv
`default_nettype none
// ============================================================================
// vip_stream_arbiter : burst round-robin share of one vip core by two pixel FIFOs
// Rev 1.0
// ============================================================================
module vip_stream_arbiter
  import vip_stream_arbiter_pkg::*;
#(
  parameter int DWIDTH    = VIP_DWIDTH,
  parameter int BURST_LEN = 640,
  parameter int TIMEOUT   = 255
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [DWIDTH-1:0] ff0_rdata_i,
  output logic              ff0_rdreq_o,
  input  logic              ff0_empty_i,
  input  logic [DWIDTH-1:0] ff1_rdata_i,
  output logic              ff1_rdreq_o,
  input  logic              ff1_empty_i,
  input  logic [1:0]        ch_en_i,
  output logic [DWIDTH-1:0] core_rdata_o,
  input  logic              core_rdreq_i,
  output logic              core_empty_o,
  output logic              grant_id_o,
  output logic              grant_vld_o,
  output logic              burst_start_o,
  output logic [15:0]       burst_cnt0_o,
  output logic [15:0]       burst_cnt1_o
);

  localparam int WW = $clog2(BURST_LEN + 1);
  localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] c_last_word = WW'(BURST_LEN - 1);
  localparam logic [SW-1:0] c_last_starve = SW'(TIMEOUT - 1);
  localparam logic          c_to_en = (TIMEOUT != 0);

  state_e          state_q;
  logic            grant_id_q;
  logic            rr_q;
  logic            burst_start_q;
  logic [15:0]     cnt0_q, cnt1_q;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [SW-1:0]   scnt_q, scnt_d;

  logic [1:0]      req;
  logic            in_gnt;
  logic            sel_empty;
  logic            fwd;
  logic            last_word;
  logic            starved;

  assign req       = ch_en_i & ~{ff1_empty_i, ff0_empty_i};
  assign in_gnt    = (state_q == ST_GNT);
  assign sel_empty = grant_id_q ? ff1_empty_i : ff0_empty_i;
  assign fwd       = in_gnt & core_rdreq_i & ~sel_empty;
  assign last_word = fwd & (wcnt_q == c_last_word);
  // The starve count is bumped on this cycle, so compare against TIMEOUT-1.
  assign starved   = c_to_en & in_gnt & sel_empty & (scnt_q == c_last_starve);

  assign ff0_rdreq_o   = fwd & ~grant_id_q;
  assign ff1_rdreq_o   = fwd & grant_id_q;
  assign core_empty_o  = ~in_gnt | sel_empty;
  assign grant_id_o    = grant_id_q;
  assign grant_vld_o   = (state_q != ST_IDLE);
  assign burst_start_o = burst_start_q;
  assign burst_cnt0_o  = cnt0_q;
  assign burst_cnt1_o  = cnt1_q;

  // FIFO data only arrives during GNT/HOLD, so IDLE can present zero.
  assign core_rdata_o = (state_q == ST_IDLE) ? '0 :
                        (grant_id_q ? ff1_rdata_i : ff0_rdata_i);

  always_comb begin
    wcnt_d = wcnt_q;
    scnt_d = scnt_q;
    if (state_q == ST_IDLE) begin
      wcnt_d = '0;
      scnt_d = '0;
    end else if (in_gnt) begin
      if (fwd) begin
        wcnt_d = wcnt_q + WW'(1);
        scnt_d = '0;
      end else if (sel_empty) begin
        scnt_d = scnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      scnt_q <= scnt_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= 1'b0;
      rr_q          <= 1'b0;
      burst_start_q <= 1'b0;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
    end else begin
      burst_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            grant_id_q    <= vip_rr_pick(req, rr_q);
            burst_start_q <= 1'b1;
            state_q       <= ST_GNT;
          end
        end
        ST_GNT: begin
          if (last_word) begin
            state_q <= ST_HOLD;
            if (grant_id_q) cnt1_q <= cnt1_q + 16'd1;
            else            cnt0_q <= cnt0_q + 16'd1;
          end else if (starved) begin
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          rr_q    <= ~grant_id_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vip_stream_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vip_stream_arbiter : vector table plus corner sequences, word scoreboard
// Rev 1.0
// ============================================================================
module tb_vip_stream_arbiter;

  localparam int DW = 24;
  localparam int BL = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] ff0_rdata = '0;
  logic [DW-1:0] ff1_rdata = '0;
  logic          ff0_rdreq, ff1_rdreq, ff0_empty, ff1_empty;
  logic [1:0]    ch_en = 2'b00;
  logic [DW-1:0] core_rdata;
  logic          core_rdreq = 1'b0;
  logic          core_empty, grant_id, grant_vld, burst_start;
  logic [15:0]   burst_cnt0, burst_cnt1;

  vip_stream_arbiter #(.DWIDTH(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .ff0_rdata_i  (ff0_rdata),
    .ff0_rdreq_o  (ff0_rdreq),
    .ff0_empty_i  (ff0_empty),
    .ff1_rdata_i  (ff1_rdata),
    .ff1_rdreq_o  (ff1_rdreq),
    .ff1_empty_i  (ff1_empty),
    .ch_en_i      (ch_en),
    .core_rdata_o (core_rdata),
    .core_rdreq_i (core_rdreq),
    .core_empty_o (core_empty),
    .grant_id_o   (grant_id),
    .grant_vld_o  (grant_vld),
    .burst_start_o(burst_start),
    .burst_cnt0_o (burst_cnt0),
    .burst_cnt1_o (burst_cnt1)
  );

  always #5 clk = ~clk;

  // Source FIFO models: one cycle read latency, underflow is sticky.
  logic [DW-1:0] mem0 [1024];
  logic [DW-1:0] mem1 [1024];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  bit uf0 = 1'b0, uf1 = 1'b0;
  assign ff0_empty = (rd0 == wr0);
  assign ff1_empty = (rd1 == wr1);

  always @(posedge clk) begin
    if (ff0_rdreq) begin
      if (rd0 == wr0) uf0 <= 1'b1;
      ff0_rdata <= mem0[rd0 % 1024];
      rd0 <= rd0 + 1;
    end
    if (ff1_rdreq) begin
      if (rd1 == wr1) uf1 <= 1'b1;
      ff1_rdata <= mem1[rd1 % 1024];
      rd1 <= rd1 + 1;
    end
  end

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [1:0] en;
    int         n0;
    int         n1;
    int         nb;
    logic [7:0] gseq;
    int         c0;
    int         c1;
  } vec_t;

  exp_t exp_q[$];
  int   runs[$];
  int   fire_cyc[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   n_fire = 0, n_bs = 0, cur_run = 0, rd_mode = 0;
  int   base0 = 0, base1 = 0, er0 = 0, er1 = 0, seq = 0;
  bit   saw1 = 1'b0, pend = 1'b0, sb_on = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req_v);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    case (rd_mode)
      0:       core_rdreq = 1'b0;
      1:       core_rdreq = 1'b1;
      default: core_rdreq = ~core_rdreq;
    endcase
    @(negedge clk);
    cyc++;
    if (ff1_rdreq) saw1 = 1'b1;
    if (burst_start) n_bs++;
    if (grant_vld) cur_run++;
    else if (cur_run > 0) begin
      runs.push_back(cur_run);
      cur_run = 0;
    end
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend && sb_on) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got %0h id %0d expected no word", core_rdata, grant_id);
        end else begin
          e = exp_q.pop_front();
          if (core_rdata !== e.data || grant_id !== e.id) begin
            errors++;
            $display("FAIL sb_word: got %0h id %0d expected %0h id %0d",
                     core_rdata, grant_id, e.data, e.id);
          end
        end
      end
      pend = core_rdreq && !core_empty;
      if (pend) begin
        n_fire++;
        fire_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rd_mode = 0;
    tick();
    tick();
    exp_q.delete();
    runs.delete();
    fire_cyc.delete();
    pend = 1'b0; n_fire = 0; n_bs = 0; cur_run = 0; saw1 = 1'b0;
    wr0 = rd0; wr1 = rd1;
    base0 = rd0; base1 = rd1;
    er0 = rd0; er1 = rd1;
  endtask

  task automatic fill(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      seq++;
      if (ch == 0) begin
        mem0[wr0 % 1024] = 24'hA00000 | 24'(seq);
        wr0++;
      end else begin
        mem1[wr1 % 1024] = 24'hB00000 | 24'(seq);
        wr1++;
      end
    end
  endtask

  task automatic expect_burst(input int ch, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.id = 1'(ch);
      if (ch == 0) begin
        e.data = mem0[er0 % 1024];
        er0++;
      end else begin
        e.data = mem1[er1 % 1024];
        er1++;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 400 && !(exp_q.size() == 0 && !grant_vld); k++) tick();
    chk(name, exp_q.size(), 0);
    repeat (4) tick();
  endtask

  initial begin
    vec_t vt[6];
    // en, n0, n1, bursts, grant order (bit b = burst b), cnt0, cnt1
    vt[0] = '{2'b11,  8, 8, 4, 8'b0000_1010, 2, 2};
    vt[1] = '{2'b01,  8, 8, 2, 8'b0000_0000, 2, 0};
    vt[2] = '{2'b10,  8, 8, 2, 8'b0000_0011, 0, 2};
    vt[3] = '{2'b11,  0, 4, 1, 8'b0000_0001, 0, 1};
    vt[4] = '{2'b11, 12, 4, 4, 8'b0000_0010, 3, 1};
    vt[5] = '{2'b00,  8, 8, 0, 8'b0000_0000, 0, 0};

    do_reset();
    chk("rst_core_empty", core_empty, 1);
    chk("rst_rdreq0", ff0_rdreq, 0);
    chk("rst_rdreq1", ff1_rdreq, 0);
    chk("rst_grant_vld", grant_vld, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_burst_start", burst_start, 0);
    chk("rst_cnt0", burst_cnt0, 0);
    chk("rst_cnt1", burst_cnt1, 0);
    chk("rst_core_rdata", core_rdata, 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      ch_en = vt[v].en;
      fill(0, vt[v].n0);
      fill(1, vt[v].n1);
      for (int b = 0; b < vt[v].nb; b++) expect_burst(int'(vt[v].gseq[b]), BL);
      rd_mode = 1;
      rst = 1'b0;
      drain($sformatf("v%0d_drain", v));
      chk($sformatf("v%0d_cnt0", v), burst_cnt0, vt[v].c0);
      chk($sformatf("v%0d_cnt1", v), burst_cnt1, vt[v].c1);
      chk($sformatf("v%0d_pops0", v), rd0 - base0, BL * vt[v].c0);
      chk($sformatf("v%0d_pops1", v), rd1 - base1, BL * vt[v].c1);
      chk($sformatf("v%0d_grants", v), n_bs, vt[v].nb);
    end

    // Reset in the middle of a second burst
    do_reset();
    sb_on = 1'b0;
    ch_en = 2'b01;
    fill(0, 8);
    rd_mode = 1;
    rst = 1'b0;
    for (int k = 0; k < 100 && burst_cnt0 != 16'd1; k++) tick();
    chk("t1_first_burst", burst_cnt0, 1);
    for (int k = 0; k < 100 && !burst_start; k++) tick();
    tick();
    tick();
    chk("t1_midburst_vld", grant_vld, 1);
    rst = 1'b1;
    tick();
    chk("t1_rdreq0", ff0_rdreq, 0);
    chk("t1_core_empty", core_empty, 1);
    chk("t1_grant_vld", grant_vld, 0);
    chk("t1_cnt0", burst_cnt0, 0);
    chk("t1_core_rdata", core_rdata, 0);
    tick();
    tick();
    sb_on = 1'b1;

    // Single channel back to back: two dead cycles between bursts
    do_reset();
    ch_en = 2'b11;
    fill(0, 8);
    expect_burst(0, BL);
    expect_burst(0, BL);
    rd_mode = 1;
    rst = 1'b0;
    drain("t2_drain");
    chk("t2_cnt0", burst_cnt0, 2);
    chk("t2_grants", n_bs, 2);
    chk("t2_no_rdreq1", saw1, 0);
    chk("t2_gap", (fire_cyc.size() >= 5) ? fire_cyc[4] - fire_cyc[3] : -1, 3);
    chk("t2_run0", (runs.size() >= 1) ? runs[0] : -1, BL + 1);

    // Starvation: 3 words then 8 empty cycles releases the grant
    do_reset();
    ch_en = 2'b11;
    fill(0, 3);
    fill(1, 4);
    expect_burst(0, 3);
    expect_burst(1, BL);
    rd_mode = 1;
    rst = 1'b0;
    drain("t4_drain");
    chk("t4_run0", (runs.size() >= 1) ? runs[0] : -1, 3 + TO + 1);
    chk("t4_run1", (runs.size() >= 2) ? runs[1] : -1, BL + 1);
    chk("t4_cnt0", burst_cnt0, 0);
    chk("t4_cnt1", burst_cnt1, 1);

    // Enable dropped mid-burst: burst completes, then nothing more
    do_reset();
    ch_en = 2'b10;
    fill(0, 8);
    fill(1, 8);
    expect_burst(1, BL);
    rd_mode = 1;
    rst = 1'b0;
    for (int k = 0; k < 100 && !burst_start; k++) tick();
    ch_en = 2'b00;
    drain("t5_drain");
    chk("t5_cnt1", burst_cnt1, 1);
    chk("t5_cnt0", burst_cnt0, 0);
    chk("t5_pops1", rd1 - base1, BL);
    chk("t5_pops0", rd0 - base0, 0);

    // Core backpressure: read request toggles every cycle
    do_reset();
    ch_en = 2'b01;
    fill(0, 4);
    expect_burst(0, BL);
    rd_mode = 2;
    rst = 1'b0;
    drain("t6_drain");
    chk("t6_cnt0", burst_cnt0, 1);
    chk("t6_fires", n_fire, BL);
    chk("t6_pops0", rd0 - base0, BL);

    chk("no_underflow", {30'd0, uf1, uf0}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
